// File: rtl/softex_stream_sched_pkg.sv
// Shared types for the SoftEx stream scheduler: FSM state encoding and the
// job descriptor captured when a job is started.
package softex_pkg;

  localparam int unsigned CFG_ADDR_W = 32;
  localparam int unsigned CFG_LEN_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    ACC,
    SAVE,
    LOAD,
    NORM,
    FINISH
  } sched_state_e;

  typedef struct packed {
    logic [CFG_ADDR_W-1:0] in_addr;
    logic [CFG_ADDR_W-1:0] out_addr;
    logic [CFG_ADDR_W-1:0] slot_addr;
    logic [CFG_ADDR_W-1:0] row_stride;
    logic [CFG_LEN_W-1:0]  row_words;
    logic [CFG_LEN_W-1:0]  n_rows;
  } job_cfg_t;

  // A job with no rows or no words per row completes without touching memory.
  function automatic logic job_is_empty(input job_cfg_t cfg);
    return (cfg.n_rows == '0) || (cfg.row_words == '0);
  endfunction

endpackage

// File: rtl/softex_stream_sched_row_addr_gen.sv
// Per-row input/output base address accumulators; bases advance by the row
// stride with a plain adder and wrap modulo 2^ADDR_WIDTH.
module softex_row_addr_gen #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic [ADDR_WIDTH-1:0] in_addr_i,
  input  logic [ADDR_WIDTH-1:0] out_addr_i,
  input  logic [ADDR_WIDTH-1:0] stride_i,
  output logic [ADDR_WIDTH-1:0] in_base_o,
  output logic [ADDR_WIDTH-1:0] out_base_o,
  output logic [ADDR_WIDTH-1:0] in_next_o
);

  logic [ADDR_WIDTH-1:0] r_stride;
  logic [ADDR_WIDTH-1:0] r_in_base;
  logic [ADDR_WIDTH-1:0] r_out_base;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stride   <= '0;
      r_in_base  <= '0;
      r_out_base <= '0;
    end else if (clear_i) begin
      r_stride   <= '0;
      r_in_base  <= '0;
      r_out_base <= '0;
    end else if (load_i) begin
      r_stride   <= stride_i;
      r_in_base  <= in_addr_i;
      r_out_base <= out_addr_i;
    end else if (step_i) begin
      r_in_base  <= in_next_o;
      r_out_base <= r_out_base + r_stride;
    end
  end

  assign in_base_o  = r_in_base;
  assign out_base_o = r_out_base;
  assign in_next_o  = r_in_base + r_stride;

endmodule

// File: rtl/softex_stream_sched.sv
// Row scheduler for SoftEx: per row it streams the input (accumulate), spills and
// reloads the accumulator slot, then streams input and output together (normalise).
module softex_stream_sched
  import softex_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned SLOT_WORDS = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] in_addr_i,
  input  logic [ADDR_WIDTH-1:0] out_addr_i,
  input  logic [ADDR_WIDTH-1:0] slot_addr_i,
  input  logic [ADDR_WIDTH-1:0] row_stride_i,
  input  logic [LEN_WIDTH-1:0]  row_words_i,
  input  logic [LEN_WIDTH-1:0]  n_rows_i,
  input  logic                  in_done_i,
  input  logic                  out_done_i,
  input  logic                  slot_in_done_i,
  input  logic                  slot_out_done_i,
  output logic                  in_start_o,
  output logic                  out_start_o,
  output logic                  slot_in_start_o,
  output logic                  slot_out_start_o,
  output logic [ADDR_WIDTH-1:0] in_base_o,
  output logic [ADDR_WIDTH-1:0] out_base_o,
  output logic [ADDR_WIDTH-1:0] slot_base_o,
  output logic [LEN_WIDTH-1:0]  in_len_o,
  output logic [LEN_WIDTH-1:0]  out_len_o,
  output logic [LEN_WIDTH-1:0]  slot_len_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [LEN_WIDTH-1:0]  row_o,
  output logic                  pass_o
);

  sched_state_e          r_state;
  logic [ADDR_WIDTH-1:0] r_slot_addr;
  logic [LEN_WIDTH-1:0]  r_row_words;
  logic [LEN_WIDTH-1:0]  r_n_rows;
  logic                  r_in_seen;
  logic                  r_out_seen;

  job_cfg_t              w_job;
  logic                  w_pulse;
  logic                  w_start_job;
  logic                  w_norm_both;
  logic                  w_last_row;
  logic                  w_step;
  logic [ADDR_WIDTH-1:0] w_in_cur;
  logic [ADDR_WIDTH-1:0] w_out_cur;
  logic [ADDR_WIDTH-1:0] w_in_next;

  always_comb begin
    w_job.in_addr    = CFG_ADDR_W'(in_addr_i);
    w_job.out_addr   = CFG_ADDR_W'(out_addr_i);
    w_job.slot_addr  = CFG_ADDR_W'(slot_addr_i);
    w_job.row_stride = CFG_ADDR_W'(row_stride_i);
    w_job.row_words  = CFG_LEN_W'(row_words_i);
    w_job.n_rows     = CFG_LEN_W'(n_rows_i);
  end

  // Done pulses coinciding with an outgoing request are stale; dropping them
  // also guarantees request pulses are never back to back.
  assign w_pulse     = in_start_o | out_start_o | slot_in_start_o | slot_out_start_o;
  assign w_start_job = (r_state == IDLE) && start_i;
  assign w_norm_both = (r_in_seen || in_done_i) && (r_out_seen || out_done_i);
  assign w_last_row  = (row_o == r_n_rows - LEN_WIDTH'(1));
  assign w_step      = (r_state == NORM) && !w_pulse && w_norm_both && !w_last_row;

  softex_row_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_row_addr_gen (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (clear_i),
    .load_i     (w_start_job),
    .step_i     (w_step),
    .in_addr_i  (ADDR_WIDTH'(w_job.in_addr)),
    .out_addr_i (ADDR_WIDTH'(w_job.out_addr)),
    .stride_i   (ADDR_WIDTH'(w_job.row_stride)),
    .in_base_o  (w_in_cur),
    .out_base_o (w_out_cur),
    .in_next_o  (w_in_next)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state          <= IDLE;
      r_slot_addr      <= '0;
      r_row_words      <= '0;
      r_n_rows         <= '0;
      r_in_seen        <= 1'b0;
      r_out_seen       <= 1'b0;
      in_start_o       <= 1'b0;
      out_start_o      <= 1'b0;
      slot_in_start_o  <= 1'b0;
      slot_out_start_o <= 1'b0;
      in_base_o        <= '0;
      out_base_o       <= '0;
      slot_base_o      <= '0;
      in_len_o         <= '0;
      out_len_o        <= '0;
      slot_len_o       <= '0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      row_o            <= '0;
      pass_o           <= 1'b0;
    end else if (clear_i) begin
      r_state          <= IDLE;
      r_slot_addr      <= '0;
      r_row_words      <= '0;
      r_n_rows         <= '0;
      r_in_seen        <= 1'b0;
      r_out_seen       <= 1'b0;
      in_start_o       <= 1'b0;
      out_start_o      <= 1'b0;
      slot_in_start_o  <= 1'b0;
      slot_out_start_o <= 1'b0;
      in_base_o        <= '0;
      out_base_o       <= '0;
      slot_base_o      <= '0;
      in_len_o         <= '0;
      out_len_o        <= '0;
      slot_len_o       <= '0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      row_o            <= '0;
      pass_o           <= 1'b0;
    end else begin
      in_start_o       <= 1'b0;
      out_start_o      <= 1'b0;
      slot_in_start_o  <= 1'b0;
      slot_out_start_o <= 1'b0;
      done_o           <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_slot_addr <= ADDR_WIDTH'(w_job.slot_addr);
            r_row_words <= LEN_WIDTH'(w_job.row_words);
            r_n_rows    <= LEN_WIDTH'(w_job.n_rows);
            r_in_seen   <= 1'b0;
            r_out_seen  <= 1'b0;
            row_o       <= '0;
            pass_o      <= 1'b0;
            busy_o      <= 1'b1;
            if (job_is_empty(w_job)) begin
              r_state <= FINISH;
            end else begin
              r_state    <= ACC;
              in_start_o <= 1'b1;
              in_base_o  <= ADDR_WIDTH'(w_job.in_addr);
              in_len_o   <= LEN_WIDTH'(w_job.row_words);
            end
          end
        end
        ACC: begin
          if (in_done_i && !w_pulse) begin
            r_state          <= SAVE;
            slot_out_start_o <= 1'b1;
            slot_base_o      <= r_slot_addr;
            slot_len_o       <= LEN_WIDTH'(SLOT_WORDS);
          end
        end
        SAVE: begin
          if (slot_out_done_i && !w_pulse) begin
            r_state         <= LOAD;
            slot_in_start_o <= 1'b1;
            pass_o          <= 1'b1;
          end
        end
        LOAD: begin
          if (slot_in_done_i && !w_pulse) begin
            r_state     <= NORM;
            in_start_o  <= 1'b1;
            out_start_o <= 1'b1;
            in_base_o   <= w_in_cur;
            out_base_o  <= w_out_cur;
            in_len_o    <= r_row_words;
            out_len_o   <= r_row_words;
            r_in_seen   <= 1'b0;
            r_out_seen  <= 1'b0;
          end
        end
        NORM: begin
          if (!w_pulse) begin
            if (w_norm_both) begin
              r_in_seen  <= 1'b0;
              r_out_seen <= 1'b0;
              pass_o     <= 1'b0;
              if (w_last_row) begin
                r_state <= FINISH;
              end else begin
                r_state    <= ACC;
                row_o      <= row_o + LEN_WIDTH'(1);
                in_start_o <= 1'b1;
                in_base_o  <= w_in_next;
                in_len_o   <= r_row_words;
              end
            end else begin
              r_in_seen  <= r_in_seen | in_done_i;
              r_out_seen <= r_out_seen | out_done_i;
            end
          end
        end
        FINISH: begin
          r_state <= IDLE;
          busy_o  <= 1'b0;
          done_o  <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_softex_stream_sched.sv
// Randomized scoreboard bench for softex_stream_sched: a job-level model queues
// the expected request/done events, a monitor checks each one as it appears.
module tb_softex_stream_sched;

  localparam int AW = 32;
  localparam int LW = 16;
  localparam int SW = 1;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          clear_i = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] in_addr_i = '0, out_addr_i = '0, slot_addr_i = '0, row_stride_i = '0;
  logic [LW-1:0] row_words_i = '0, n_rows_i = '0;
  logic          in_done_i = 1'b0, out_done_i = 1'b0, slot_in_done_i = 1'b0, slot_out_done_i = 1'b0;
  logic          in_start_o, out_start_o, slot_in_start_o, slot_out_start_o;
  logic [AW-1:0] in_base_o, out_base_o, slot_base_o;
  logic [LW-1:0] in_len_o, out_len_o, slot_len_o, row_o;
  logic          busy_o, done_o, pass_o;

  softex_stream_sched #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .SLOT_WORDS(SW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .in_addr_i(in_addr_i), .out_addr_i(out_addr_i), .slot_addr_i(slot_addr_i),
    .row_stride_i(row_stride_i), .row_words_i(row_words_i), .n_rows_i(n_rows_i),
    .in_done_i(in_done_i), .out_done_i(out_done_i),
    .slot_in_done_i(slot_in_done_i), .slot_out_done_i(slot_out_done_i),
    .in_start_o(in_start_o), .out_start_o(out_start_o),
    .slot_in_start_o(slot_in_start_o), .slot_out_start_o(slot_out_start_o),
    .in_base_o(in_base_o), .out_base_o(out_base_o), .slot_base_o(slot_base_o),
    .in_len_o(in_len_o), .out_len_o(out_len_o), .slot_len_o(slot_len_o),
    .busy_o(busy_o), .done_o(done_o), .row_o(row_o), .pass_o(pass_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 1 = input stream (accumulate), 2 = slot save, 3 = slot load,
  //       4 = input+output stream (normalise), 5 = job done
  typedef struct {
    int          kind;
    logic [31:0] base_a;
    logic [31:0] base_b;
    logic [15:0] len;
    logic [15:0] row;
    logic        pass;
    logic        busy;
    int          lat;
  } ev_t;

  ev_t sb[$];
  int  nd_in[$];
  int  nd_out[$];
  int  total = 0;
  int  bad = 0;
  int  trig_cyc = 0;
  int  done_seen = 0;
  bit  resp_flush = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic ev_t mk(input int kind, input logic [31:0] a, input logic [31:0] b,
                             input logic [15:0] len, input logic [15:0] row,
                             input logic pass, input logic busy, input int lat);
    ev_t e;
    e.kind = kind; e.base_a = a; e.base_b = b; e.len = len;
    e.row = row; e.pass = pass; e.busy = busy; e.lat = lat;
    return e;
  endfunction

  // Reference model: the whole job's request sequence, straight from the row rules.
  task automatic push_job(input logic [31:0] ia, input logic [31:0] oa, input logic [31:0] sa,
                          input logic [31:0] st, input logic [15:0] rw, input logic [15:0] nr);
    if (nr == 0 || rw == 0) begin
      sb.push_back(mk(5, 0, 0, 0, 0, 1'b0, 1'b0, 2));
    end else begin
      for (int r = 0; r < int'(nr); r++) begin
        logic [31:0] ib, ob;
        ib = ia + st * 32'(r);
        ob = oa + st * 32'(r);
        sb.push_back(mk(1, ib, 0, rw, 16'(r), 1'b0, 1'b1, 1));
        sb.push_back(mk(2, sa, 0, 16'(SW), 16'(r), 1'b0, 1'b1, 1));
        sb.push_back(mk(3, sa, 0, 16'(SW), 16'(r), 1'b1, 1'b1, 1));
        sb.push_back(mk(4, ib, ob, rw, 16'(r), 1'b1, 1'b1, 1));
      end
      sb.push_back(mk(5, 0, 0, 0, 0, 1'b0, 1'b0, 2));
    end
  endtask

  // Monitor
  initial begin
    bit prev_start = 1'b0;
    forever begin
      logic [3:0] starts;
      int         kind;
      ev_t        e;
      @(negedge clk);
      starts = {in_start_o, out_start_o, slot_in_start_o, slot_out_start_o};
      if (starts != 4'b0000 || done_o) begin
        case ({done_o, starts})
          5'b01000: kind = 1;
          5'b00001: kind = 2;
          5'b00010: kind = 3;
          5'b01100: kind = 4;
          5'b10000: kind = 5;
          default:  kind = 0;
        endcase
        if (starts != 4'b0000) chk("no_back_to_back", 64'(prev_start), 64'd0);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: got kind %0d starts=%b done=%b expected none (cycle %0d)",
                   kind, starts, done_o, cyc);
        end else begin
          e = sb.pop_front();
          $display("event cyc=%0d kind=%0d row=%0d in=%h out=%h slot=%h", cyc, kind, row_o,
                   in_base_o, out_base_o, slot_base_o);
          chk("kind", 64'(kind), 64'(e.kind));
          chk("latency", 64'(cyc - trig_cyc), 64'(e.lat));
          chk("pass", 64'(pass_o), 64'(e.pass));
          chk("busy", 64'(busy_o), 64'(e.busy));
          case (e.kind)
            1: begin
              chk("acc_in_base", 64'(in_base_o), 64'(e.base_a));
              chk("acc_in_len", 64'(in_len_o), 64'(e.len));
            end
            2, 3: begin
              chk("slot_base", 64'(slot_base_o), 64'(e.base_a));
              chk("slot_len", 64'(slot_len_o), 64'(e.len));
            end
            4: begin
              chk("norm_in_base", 64'(in_base_o), 64'(e.base_a));
              chk("norm_out_base", 64'(out_base_o), 64'(e.base_b));
              chk("norm_in_len", 64'(in_len_o), 64'(e.len));
              chk("norm_out_len", 64'(out_len_o), 64'(e.len));
            end
            default: ;
          endcase
          if (e.kind != 5) chk("row", 64'(row_o), 64'(e.row));
        end
        if (done_o) done_seen++;
      end
      prev_start = (starts != 4'b0000);
    end
  end

  // Streamer responder: answers each request after a random delay, injects stray dones.
  initial begin
    int c_in = 0, c_out = 0, c_si = 0, c_so = 0, phase = 0;
    bit norm_p = 1'b0, got_in = 1'b0, got_out = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      in_done_i = 1'b0; out_done_i = 1'b0; slot_in_done_i = 1'b0; slot_out_done_i = 1'b0;
      if (resp_flush) begin
        c_in = 0; c_out = 0; c_si = 0; c_so = 0; phase = 0;
        norm_p = 1'b0; got_in = 1'b0; got_out = 1'b0; resp_flush = 1'b0;
      end
      if (c_in > 0) begin
        c_in--;
        if (c_in == 0) begin
          in_done_i = 1'b1;
          if (norm_p) got_in = 1'b1;
          else begin trig_cyc = cyc; phase = 0; end
        end
      end
      if (c_out > 0) begin
        c_out--;
        if (c_out == 0) begin out_done_i = 1'b1; got_out = 1'b1; end
      end
      if (c_so > 0) begin
        c_so--;
        if (c_so == 0) begin slot_out_done_i = 1'b1; trig_cyc = cyc; end
      end
      if (c_si > 0) begin
        c_si--;
        if (c_si == 0) begin slot_in_done_i = 1'b1; trig_cyc = cyc; end
      end
      if (norm_p && got_in && got_out) begin
        trig_cyc = cyc; norm_p = 1'b0; phase = 0;
      end
      if (phase == 1 && $urandom_range(0, 2) == 0) slot_in_done_i = 1'b1;
      if (phase == 2 && $urandom_range(0, 2) == 0) slot_out_done_i = 1'b1;
      if (in_start_o && out_start_o) begin
        norm_p = 1'b1; got_in = 1'b0; got_out = 1'b0; phase = 2;
        if (nd_in.size() > 0) begin
          c_in = nd_in.pop_front();
          c_out = nd_out.pop_front();
        end else begin
          c_in = int'($urandom_range(1, 5));
          c_out = int'($urandom_range(1, 5));
        end
      end else if (in_start_o) begin
        c_in = int'($urandom_range(1, 5)); phase = 1;
      end else if (slot_out_start_o) begin
        c_so = int'($urandom_range(1, 4));
      end else if (slot_in_start_o) begin
        c_si = int'($urandom_range(1, 4));
      end
    end
  end

  task automatic drive_cfg(input logic [31:0] ia, input logic [31:0] oa, input logic [31:0] sa,
                           input logic [31:0] st, input logic [15:0] rw, input logic [15:0] nr);
    in_addr_i = ia; out_addr_i = oa; slot_addr_i = sa;
    row_stride_i = st; row_words_i = rw; n_rows_i = nr;
  endtask

  task automatic run_job(input logic [31:0] ia, input logic [31:0] oa, input logic [31:0] sa,
                         input logic [31:0] st, input logic [15:0] rw, input logic [15:0] nr);
    int d0;
    @(posedge clk);
    #1;
    drive_cfg(ia, oa, sa, st, rw, nr);
    push_job(ia, oa, sa, st, rw, nr);
    d0 = done_seen;
    start_i = 1'b1;
    trig_cyc = cyc;
    for (int i = 0; i < 3000 && done_seen == d0; i++) begin
      @(posedge clk);
      #1;
      // Garbage config and start attempts while busy must not disturb the job.
      start_i = busy_o && ($urandom_range(0, 7) == 0);
      if (busy_o) drive_cfg($urandom, $urandom, $urandom, $urandom, 16'($urandom), 16'($urandom));
    end
    start_i = 1'b0;
    chk("job_done_count", 64'(done_seen - d0), 64'd1);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    bit found;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_starts", 64'({in_start_o, out_start_o, slot_in_start_o, slot_out_start_o}), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_pass", 64'(pass_o), 64'd0);
    chk("rst_row", 64'(row_o), 64'd0);
    chk("rst_bases", 64'(in_base_o | out_base_o | slot_base_o), 64'd0);
    chk("rst_lens", 64'(in_len_o | out_len_o | slot_len_o), 64'd0);
    rst_ni = 1'b1;

    run_job(32'h1000, 32'h2000, 32'h3000, 32'h40, 16'd16, 16'd3);
    run_job(32'h1000, 32'h2000, 32'h3000, 32'h40, 16'd16, 16'd0);
    run_job(32'h1000, 32'h2000, 32'h3000, 32'h40, 16'd0, 16'd2);
    // Normalise: output done 5 cycles ahead of input done, then both together.
    nd_in.push_back(6); nd_out.push_back(1);
    nd_in.push_back(3); nd_out.push_back(3);
    run_job(32'h4000, 32'h5000, 32'h6000, 32'h100, 16'd8, 16'd2);
    run_job(32'hFFFF_FFC0, 32'hFFFF_FF80, 32'h7000, 32'h40, 16'd4, 16'd2);

    // Clear while saving the slot of row 1, then a fresh job.
    @(posedge clk);
    #1;
    drive_cfg(32'h1000, 32'h2000, 32'h3000, 32'h40, 16'd8, 16'd3);
    push_job(32'h1000, 32'h2000, 32'h3000, 32'h40, 16'd8, 16'd3);
    start_i = 1'b1;
    trig_cyc = cyc;
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(posedge clk);
      #1;
      start_i = 1'b0;
      if (slot_out_start_o && row_o == 16'd1) found = 1'b1;
    end
    chk("clear_reached_save_row1", 64'(found), 64'd1);
    clear_i = 1'b1;
    @(posedge clk);
    #1;
    clear_i = 1'b0;
    sb.delete();
    resp_flush = 1'b1;
    chk("clr_busy", 64'(busy_o), 64'd0);
    chk("clr_done", 64'(done_o), 64'd0);
    chk("clr_pass", 64'(pass_o), 64'd0);
    chk("clr_row", 64'(row_o), 64'd0);
    chk("clr_bases", 64'(in_base_o | out_base_o | slot_base_o), 64'd0);
    chk("clr_lens", 64'(in_len_o | out_len_o | slot_len_o), 64'd0);
    repeat (10) @(posedge clk);
    run_job(32'h8000, 32'h9000, 32'hA000, 32'h20, 16'd5, 16'd2);

    for (int j = 0; j < 20; j++) begin
      logic [31:0] st;
      st = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255)) << 2;
      run_job($urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
              st, 16'($urandom_range(0, 20)), 16'($urandom_range(0, 4)));
    end

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
